// File: rtl/rs_issue_queue_pkg.sv
// Shared types, sizes and helper functions for the 16-entry reservation station
// and its oldest-PC-first selection tree.
package rs_issue_queue_pkg;

  localparam int RS_SIZE = 16;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 6;
  localparam int OP_W    = 5;
  localparam int IDX_W   = $clog2(RS_SIZE);
  localparam int CNT_W   = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] src1;
    logic             rdy1;
    logic [TAG_W-1:0] src2;
    logic             rdy2;
  } rs_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] src1;
    logic [TAG_W-1:0] src2;
  } issue_pkt_t;

  // One node of the selection tree: the winning request below it.
  typedef struct packed {
    logic             req;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  pc;
  } sel_node_t;

  // Upper child wins only with a strictly smaller PC; ties stay with the lower index.
  function automatic sel_node_t sel_merge(input sel_node_t lo, input sel_node_t hi);
    if (hi.req && (!lo.req || (hi.pc < lo.pc))) return hi;
    return lo;
  endfunction

  // Fixed-priority selector: one-hot of the highest set bit.
  function automatic logic [RS_SIZE-1:0] fp_sel_msb(input logic [RS_SIZE-1:0] v);
    logic [RS_SIZE-1:0] oh;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (v[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [RS_SIZE-1:0] bit_rev(input logic [RS_SIZE-1:0] v);
    logic [RS_SIZE-1:0] r;
    for (int i = 0; i < RS_SIZE; i++) r[i] = v[RS_SIZE-1-i];
    return r;
  endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB, squash and issue-slot signals of the reservation station.
// master = dispatch/FU side, slave = the reservation station.
interface rs_issue_queue_if;
  import rs_issue_queue_pkg::*;

  logic             dispatch_valid;
  logic [XLEN-1:0]  dispatch_pc;
  logic [OP_W-1:0]  dispatch_op;
  logic [TAG_W-1:0] dispatch_dest;
  logic [TAG_W-1:0] dispatch_src1;
  logic [TAG_W-1:0] dispatch_src2;
  logic             dispatch_rdy1;
  logic             dispatch_rdy2;
  logic             dispatch_ready;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             squash;
  logic             issue_valid;
  logic [XLEN-1:0]  issue_pc;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_dest;
  logic [TAG_W-1:0] issue_src1;
  logic [TAG_W-1:0] issue_src2;
  logic             issue_ready;
  logic [CNT_W-1:0] free_count;

  modport master (
    output dispatch_valid, dispatch_pc, dispatch_op, dispatch_dest,
           dispatch_src1, dispatch_src2, dispatch_rdy1, dispatch_rdy2,
           cdb_valid, cdb_tag, squash, issue_ready,
    input  dispatch_ready, issue_valid, issue_pc, issue_op, issue_dest,
           issue_src1, issue_src2, free_count
  );

  modport slave (
    input  dispatch_valid, dispatch_pc, dispatch_op, dispatch_dest,
           dispatch_src1, dispatch_src2, dispatch_rdy1, dispatch_rdy2,
           cdb_valid, cdb_tag, squash, issue_ready,
    output dispatch_ready, issue_valid, issue_pc, issue_op, issue_dest,
           issue_src1, issue_src2, free_count
  );

endinterface

// File: rtl/rs_oldest_sel16.sv
// 16-way oldest-PC-first selector: a 4-level binary tree of 2-way compare nodes
// producing a one-hot grant plus the winning request/PC.
module rs_oldest_sel16
  import rs_issue_queue_pkg::*;
(
  input  logic                 i_en,
  input  logic [15:0]          i_req,
  input  logic [15:0][XLEN-1:0] i_pc,
  output logic [15:0]          o_gnt,
  output logic                 o_req_up,
  output logic [XLEN-1:0]      o_pc_up
);

  sel_node_t w_l0 [16];
  sel_node_t w_l1 [8];
  sel_node_t w_l2 [4];
  sel_node_t w_l3 [2];
  sel_node_t w_root;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_l0[i].req = i_req[i];
      w_l0[i].idx = 4'(i);
      w_l0[i].pc  = i_pc[i];
    end
    for (int i = 0; i < 8; i++) w_l1[i] = sel_merge(w_l0[2*i], w_l0[2*i+1]);
    for (int i = 0; i < 4; i++) w_l2[i] = sel_merge(w_l1[2*i], w_l1[2*i+1]);
    for (int i = 0; i < 2; i++) w_l3[i] = sel_merge(w_l2[2*i], w_l2[2*i+1]);
    w_root = sel_merge(w_l3[0], w_l3[1]);
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    o_gnt = '0;
    if (i_en && w_root.req) o_gnt[w_root.idx] = 1'b1;
  end

  assign o_req_up = w_root.req;
  assign o_pc_up  = w_root.pc;

endmodule

// File: rtl/rs_issue_queue.sv
// 16-entry reservation station: CDB wakeup, oldest-PC-first select and a
// registered issue slot with valid/ready handshake to the functional unit.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
(
  input logic             clock,
  input logic             reset,
  rs_issue_queue_if.slave rs_if
);

  rs_entry_t                      r_ent [RS_SIZE];
  logic [CNT_W-1:0]               r_free_count;
  logic                           r_issue_valid;
  issue_pkt_t                     r_issue;

  logic [RS_SIZE-1:0]             w_valid;
  logic [RS_SIZE-1:0]             w_req;
  logic [RS_SIZE-1:0][XLEN-1:0]   w_pc;
  logic [RS_SIZE-1:0]             w_free_oh;
  logic [RS_SIZE-1:0]             w_gnt;
  logic                           w_req_up;
  logic [XLEN-1:0]                w_pc_up;
  logic                           w_slot_load;
  logic                           w_take;
  logic                           w_disp;
  rs_entry_t                      w_new;
  issue_pkt_t                     w_pick;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_req[i]   = r_ent[i].valid & r_ent[i].rdy1 & r_ent[i].rdy2;
      w_pc[i]    = r_ent[i].pc;
    end
  end

  assign w_slot_load = !r_issue_valid || rs_if.issue_ready;
  assign w_take      = w_req_up && w_slot_load;
  assign w_disp      = rs_if.dispatch_valid && (r_free_count != '0) && !rs_if.squash;
  // Lowest free index: the MSB-priority selector fed with bit-reversed ~valid.
  assign w_free_oh   = bit_rev(fp_sel_msb(bit_rev(~w_valid)));

  rs_oldest_sel16 u_sel (
    .i_en     (w_slot_load),
    .i_req    (w_req),
    .i_pc     (w_pc),
    .o_gnt    (w_gnt),
    .o_req_up (w_req_up),
    .o_pc_up  (w_pc_up)
  );

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.pc    = rs_if.dispatch_pc;
    w_new.op    = rs_if.dispatch_op;
    w_new.dest  = rs_if.dispatch_dest;
    w_new.src1  = rs_if.dispatch_src1;
    w_new.src2  = rs_if.dispatch_src2;
    // Same-cycle CDB bypass so a dispatching consumer never misses its producer.
    w_new.rdy1  = rs_if.dispatch_rdy1 | (rs_if.cdb_valid && (rs_if.dispatch_src1 == rs_if.cdb_tag));
    w_new.rdy2  = rs_if.dispatch_rdy2 | (rs_if.cdb_valid && (rs_if.dispatch_src2 == rs_if.cdb_tag));
  end

  always_comb begin
    w_pick    = '0;
    w_pick.pc = w_pc_up;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_gnt[i]) begin
        w_pick.op   = r_ent[i].op;
        w_pick.dest = r_ent[i].dest;
        w_pick.src1 = r_ent[i].src1;
        w_pick.src2 = r_ent[i].src2;
      end
    end
  end

  // NOTE: the entry array is a bank of flops, not a RAM, so it is reset in full;
  // that keeps valid and payload in one async-reset flop group.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_free_count <= CNT_W'(RS_SIZE);
    end else if (rs_if.squash) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i].valid <= 1'b0;
      r_free_count <= CNT_W'(RS_SIZE);
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_disp && w_free_oh[i]) begin
          r_ent[i] <= w_new;
        end else begin
          if (w_gnt[i]) r_ent[i].valid <= 1'b0;
          if (rs_if.cdb_valid && r_ent[i].valid && (r_ent[i].src1 == rs_if.cdb_tag))
            r_ent[i].rdy1 <= 1'b1;
          if (rs_if.cdb_valid && r_ent[i].valid && (r_ent[i].src2 == rs_if.cdb_tag))
            r_ent[i].rdy2 <= 1'b1;
        end
      end
      r_free_count <= r_free_count - CNT_W'(w_disp) + CNT_W'(w_take);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_issue_valid <= 1'b0;
      r_issue       <= '0;
    end else if (rs_if.squash) begin
      r_issue_valid <= 1'b0;
    end else if (w_slot_load) begin
      r_issue_valid <= w_take;
      if (w_take) r_issue <= w_pick;
    end
  end

  assign rs_if.dispatch_ready = (r_free_count != '0);
  assign rs_if.free_count     = r_free_count;
  assign rs_if.issue_valid    = r_issue_valid;
  assign rs_if.issue_pc       = r_issue.pc;
  assign rs_if.issue_op       = r_issue.op;
  assign rs_if.issue_dest     = r_issue.dest;
  assign rs_if.issue_src1     = r_issue.src1;
  assign rs_if.issue_src2     = r_issue.src2;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: directed scenarios with a scoreboard
// of expected issue packets popped whenever the FU accepts the slot.
module tb_rs_issue_queue;
  import rs_issue_queue_pkg::*;

  logic clock;
  logic reset;

  rs_issue_queue_if ifc ();

  rs_issue_queue dut (
    .clock (clock),
    .reset (reset),
    .rs_if (ifc)
  );

  int         n_total;
  int         n_bad;
  issue_pkt_t sb_q [$];
  issue_pkt_t mon_exp;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifc.dispatch_valid = 1'b0;
    ifc.cdb_valid      = 1'b0;
    ifc.squash         = 1'b0;
  endtask

  task automatic drive_disp(input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] dest,
                            input logic [TAG_W-1:0] s1, input logic r1,
                            input logic [TAG_W-1:0] s2, input logic r2);
    ifc.dispatch_valid = 1'b1;
    ifc.dispatch_pc    = pc;
    ifc.dispatch_op    = dest[OP_W-1:0];
    ifc.dispatch_dest  = dest;
    ifc.dispatch_src1  = s1;
    ifc.dispatch_rdy1  = r1;
    ifc.dispatch_src2  = s2;
    ifc.dispatch_rdy2  = r2;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] dest,
                          input logic [TAG_W-1:0] s1, input logic [TAG_W-1:0] s2);
    issue_pkt_t p;
    p.pc   = pc;
    p.op   = dest[OP_W-1:0];
    p.dest = dest;
    p.src1 = s1;
    p.src2 = s2;
    sb_q.push_back(p);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(sb_q.size()), 64'd0);
  endtask

  // The FU takes the slot at the coming edge when valid && ready at mid-cycle.
  always @(negedge clock) begin
    if (reset && ifc.issue_valid && ifc.issue_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_issue", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_pc",   64'(ifc.issue_pc),   64'(mon_exp.pc));
        check("sb_dest", 64'(ifc.issue_dest), 64'(mon_exp.dest));
        check("sb_op",   64'(ifc.issue_op),   64'(mon_exp.op));
        check("sb_src1", 64'(ifc.issue_src1), 64'(mon_exp.src1));
        check("sb_src2", 64'(ifc.issue_src2), 64'(mon_exp.src2));
      end
    end
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    ifc.dispatch_valid = 1'b0;
    ifc.dispatch_pc    = '0;
    ifc.dispatch_op    = '0;
    ifc.dispatch_dest  = '0;
    ifc.dispatch_src1  = '0;
    ifc.dispatch_src2  = '0;
    ifc.dispatch_rdy1  = 1'b0;
    ifc.dispatch_rdy2  = 1'b0;
    ifc.cdb_valid      = 1'b0;
    ifc.cdb_tag        = '0;
    ifc.squash         = 1'b0;
    ifc.issue_ready    = 1'b0;

    // Reset state
    #12;
    check("rst_free",   64'(ifc.free_count),     64'd16);
    check("rst_dready", 64'(ifc.dispatch_ready), 64'd1);
    check("rst_ivalid", 64'(ifc.issue_valid),    64'd0);
    check("rst_ipc",    64'(ifc.issue_pc),       64'd0);
    reset = 1'b1;
    step();

    // Single ready dispatch: issue two edges later, free_count 16->15->16
    ifc.issue_ready = 1'b1;
    push_exp(32'h100, 6'd1, 6'd2, 6'd3);
    drive_disp(32'h100, 6'd1, 6'd2, 1'b1, 6'd3, 1'b1);
    step(); idle();
    check("s1_free_disp",   64'(ifc.free_count),  64'd15);
    check("s1_ivalid_early", 64'(ifc.issue_valid), 64'd0);
    step();
    check("s1_ivalid", 64'(ifc.issue_valid), 64'd1);
    check("s1_ipc",    64'(ifc.issue_pc),    64'h100);
    check("s1_free_issue", 64'(ifc.free_count), 64'd16);
    step();
    check("s1_ivalid_drop", 64'(ifc.issue_valid), 64'd0);

    // Back-to-back ready dispatches: each is alone when selected
    push_exp(32'h300, 6'd2, 6'd1, 6'd1);
    push_exp(32'h200, 6'd3, 6'd1, 6'd1);
    push_exp(32'h100, 6'd4, 6'd1, 6'd1);
    drive_disp(32'h300, 6'd2, 6'd1, 1'b1, 6'd1, 1'b1); step();
    drive_disp(32'h200, 6'd3, 6'd1, 1'b1, 6'd1, 1'b1); step();
    drive_disp(32'h100, 6'd4, 6'd1, 1'b1, 6'd1, 1'b1); step();
    idle();
    wait_drain("s2a_drain", 10);

    // Three waiting entries woken together: oldest PC first
    drive_disp(32'h300, 6'd5, 6'd9, 1'b0, 6'd1, 1'b1); step();
    drive_disp(32'h200, 6'd6, 6'd9, 1'b0, 6'd1, 1'b1); step();
    drive_disp(32'h100, 6'd7, 6'd9, 1'b0, 6'd1, 1'b1); step();
    idle();
    step();
    check("s2b_not_ready", 64'(ifc.issue_valid), 64'd0);
    push_exp(32'h100, 6'd7, 6'd9, 6'd1);
    push_exp(32'h200, 6'd6, 6'd9, 6'd1);
    push_exp(32'h300, 6'd5, 6'd9, 6'd1);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd9;
    step(); idle();
    wait_drain("s2b_drain", 10);

    // CDB wakeup latency: issue_valid exactly two cycles after the CDB cycle
    push_exp(32'h40, 6'd8, 6'd7, 6'd10);
    drive_disp(32'h40, 6'd8, 6'd7, 1'b0, 6'd10, 1'b1);
    step(); idle();
    step();
    check("s3_wait", 64'(ifc.issue_valid), 64'd0);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd7;
    step(); idle();
    check("s3_cdb_t1", 64'(ifc.issue_valid), 64'd0);
    step();
    check("s3_cdb_t2_valid", 64'(ifc.issue_valid), 64'd1);
    check("s3_cdb_t2_pc",    64'(ifc.issue_pc),    64'h40);
    step();
    check("s3_drop", 64'(ifc.issue_valid), 64'd0);

    // Dispatch and CDB in the same cycle: stored ready
    push_exp(32'h44, 6'd9, 6'd7, 6'd11);
    drive_disp(32'h44, 6'd9, 6'd7, 1'b0, 6'd11, 1'b1);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd7;
    step(); idle();
    check("s3_byp_t1", 64'(ifc.issue_valid), 64'd0);
    step();
    check("s3_byp_valid", 64'(ifc.issue_valid), 64'd1);
    check("s3_byp_pc",    64'(ifc.issue_pc),    64'h44);
    step();

    // Tag 0 waits for a CDB like any other tag
    push_exp(32'h48, 6'd12, 6'd0, 6'd0);
    drive_disp(32'h48, 6'd12, 6'd0, 1'b0, 6'd0, 1'b0);
    step(); idle();
    step();
    check("s3_tag0_wait", 64'(ifc.issue_valid), 64'd0);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd0;
    step(); idle();
    step();
    check("s3_tag0_valid", 64'(ifc.issue_valid), 64'd1);
    check("s3_tag0_pc",    64'(ifc.issue_pc),    64'h48);
    step();

    // Back-pressure: slot holds, three ready entries stay resident
    ifc.issue_ready = 1'b0;
    drive_disp(32'h50, 6'd13, 6'd1, 1'b1, 6'd1, 1'b1); step();
    drive_disp(32'h700, 6'd16, 6'd1, 1'b1, 6'd1, 1'b1); step();
    drive_disp(32'h600, 6'd15, 6'd1, 1'b1, 6'd1, 1'b1); step();
    drive_disp(32'h500, 6'd14, 6'd1, 1'b1, 6'd1, 1'b1); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      check("s4_hold_valid", 64'(ifc.issue_valid), 64'd1);
      check("s4_hold_pc",    64'(ifc.issue_pc),    64'h50);
      check("s4_hold_free",  64'(ifc.free_count),  64'd13);
      step();
    end
    push_exp(32'h50,  6'd13, 6'd1, 6'd1);
    push_exp(32'h500, 6'd14, 6'd1, 6'd1);
    push_exp(32'h600, 6'd15, 6'd1, 6'd1);
    push_exp(32'h700, 6'd16, 6'd1, 6'd1);
    ifc.issue_ready = 1'b1;
    step();
    check("s4_rel1_pc",   64'(ifc.issue_pc),   64'h500);
    check("s4_rel1_free", 64'(ifc.free_count), 64'd14);
    step();
    check("s4_rel2_pc",   64'(ifc.issue_pc),   64'h600);
    check("s4_rel2_free", 64'(ifc.free_count), 64'd15);
    step();
    check("s4_rel3_pc",   64'(ifc.issue_pc),   64'h700);
    check("s4_rel3_free", 64'(ifc.free_count), 64'd16);
    step();
    check("s4_empty", 64'(ifc.issue_valid), 64'd0);
    check("s4_sb",    64'(sb_q.size()),     64'd0);

    // Fill all 16 entries, drop a 17th, free one by issue, then squash
    ifc.issue_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_disp(32'h1000 + 32'(i) * 32'h10, TAG_W'(i), (i == 5) ? 6'd20 : 6'd21, 1'b0, 6'd1, 1'b1);
      step();
    end
    idle();
    check("s5_full_free",   64'(ifc.free_count),     64'd0);
    check("s5_full_dready", 64'(ifc.dispatch_ready), 64'd0);
    drive_disp(32'hdead0, 6'd40, 6'd1, 1'b1, 6'd1, 1'b1);
    step(); idle();
    check("s5_drop_free", 64'(ifc.free_count), 64'd0);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd20;
    step(); idle();
    check("s5_wake_dready", 64'(ifc.dispatch_ready), 64'd0);
    step();
    check("s5_issue_valid",  64'(ifc.issue_valid),    64'd1);
    check("s5_issue_pc",     64'(ifc.issue_pc),       64'h1050);
    check("s5_issue_free",   64'(ifc.free_count),     64'd1);
    check("s5_issue_dready", 64'(ifc.dispatch_ready), 64'd1);
    drive_disp(32'h2000, 6'd41, 6'd1, 1'b1, 6'd1, 1'b1);
    ifc.squash = 1'b1;
    step(); idle();
    check("s5_sq_valid",  64'(ifc.issue_valid),    64'd0);
    check("s5_sq_free",   64'(ifc.free_count),     64'd16);
    check("s5_sq_dready", 64'(ifc.dispatch_ready), 64'd1);
    step();
    check("s5_sq_free2", 64'(ifc.free_count), 64'd16);
    check("s5_sq_valid2", 64'(ifc.issue_valid), 64'd0);

    // Equal PCs in entries 3 and 9: the lower index wins
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 9)
        drive_disp(32'h80, TAG_W'(i), 6'd31, 1'b0, 6'd1, 1'b1);
      else
        drive_disp(32'h90 + 32'(i), TAG_W'(i), 6'd30, 1'b0, 6'd1, 1'b1);
      step();
    end
    idle();
    push_exp(32'h80, 6'd3, 6'd31, 6'd1);
    push_exp(32'h80, 6'd9, 6'd31, 6'd1);
    ifc.cdb_valid = 1'b1; ifc.cdb_tag = 6'd31;
    step(); idle();
    ifc.issue_ready = 1'b1;
    wait_drain("s6_drain", 10);
    check("s6_rest_free", 64'(ifc.free_count), 64'd8);
    ifc.issue_ready = 1'b0;
    ifc.squash = 1'b1;
    step(); idle();
    check("s6_sq_free", 64'(ifc.free_count), 64'd16);

    // Asynchronous reset mid-cycle drops the slot and all entries at once
    drive_disp(32'h900, 6'd20, 6'd1, 1'b1, 6'd1, 1'b1); step(); idle();
    step();
    drive_disp(32'h910, 6'd21, 6'd1, 1'b1, 6'd1, 1'b1); step(); idle();
    check("s7_pre_valid", 64'(ifc.issue_valid), 64'd1);
    check("s7_pre_free",  64'(ifc.free_count),  64'd15);
    #3;
    reset = 1'b0;
    #1;
    check("s7_rst_valid",  64'(ifc.issue_valid),    64'd0);
    check("s7_rst_free",   64'(ifc.free_count),     64'd16);
    check("s7_rst_pc",     64'(ifc.issue_pc),       64'd0);
    check("s7_rst_dready", 64'(ifc.dispatch_ready), 64'd1);
    #10;
    reset = 1'b1;
    step();
    check("s7_post_free",  64'(ifc.free_count),  64'd16);
    check("s7_post_valid", 64'(ifc.issue_valid), 64'd0);
    ifc.issue_ready = 1'b1;
    push_exp(32'ha00, 6'd22, 6'd1, 6'd1);
    drive_disp(32'ha00, 6'd22, 6'd1, 1'b1, 6'd1, 1'b1);
    step(); idle();
    wait_drain("s7_drain", 10);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- 16-entry reservation station. Sits directly upstream of the oldest-first PC selection tree.
- Holds dispatched instructions and tracks source-operand readiness through CDB wakeup.
- Drives the request and PC vectors into an oldest-PC-first selector. Latches the granted entry into a registered issue slot with a valid/ready handshake to the functional unit.

Parameters:
- RS_SIZE, 16, number of entries (power of two; selector is built for 16).
- XLEN, 32, PC width.
- TAG_W, 6, physical register tag width.
- OP_W, 5, opcode/control field width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- dispatch_valid  in  1  dispatch request this cycle.
- dispatch_pc  in  XLEN  instruction PC.
- dispatch_op  in  OP_W  opcode.
- dispatch_dest  in  TAG_W  destination tag.
- dispatch_src1 / dispatch_src2  in  TAG_W each  source tags.
- dispatch_rdy1 / dispatch_rdy2  in  1 each  source already available.
- dispatch_ready  out  1  free_count != 0.
- cdb_valid  in  1  completion broadcast valid.
- cdb_tag  in  TAG_W  completing tag.
- squash  in  1  flush all state.
- issue_valid  out  1  issue slot holds an instruction.
- issue_pc / issue_op / issue_dest / issue_src1 / issue_src2  out  issue slot contents.
- issue_ready  in  1  FU accepts the issue slot this cycle.
- free_count  out  $clog2(RS_SIZE)+1  number of invalid entries.

Behaviour:
- Reset (reset==0, async):
  - All entry valid bits = 0; issue_valid = 0; issue payload = 0.
  - free_count = RS_SIZE; dispatch_ready = 1.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready && !squash.
  - Written into the lowest-index invalid entry, using the pre-edge valid vector.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
  - dispatch_valid while full is ignored; no state change.
- Wakeup:
  - When cdb_valid, every valid entry with src tag == cdb_tag sets that ready bit at the edge.
  - Same-cycle bypass: if a dispatching src tag == cdb_tag with cdb_valid, the ready bit is stored as 1.
  - Tag 0 is not special.
- Request vector: req[i] = valid[i] & rdy1[i] & rdy2[i]. Wakeup is registered, so a CDB hit in cycle t makes the entry eligible in cycle t+1.
- Selection:
  - Combinational, oldest = smallest PC (unsigned compare). No request gives no grant.
  - Binary tree of 2-way nodes. Each node prefers its upper child only when that child's PC is strictly smaller; equal PCs go to the lower child.
  - Enabled only when slot_load = !issue_valid || issue_ready.
- Issue slot:
  - On slot_load with a grant: the selected entry's fields load into the slot, issue_valid = 1, and the entry's valid clears at the same edge.
  - On slot_load with no grant: issue_valid = 0.
  - When issue_valid && !issue_ready: slot holds, and no entry is removed.
- Latency:
  - Dispatch with both operands ready at cycle t gives issue_valid at t+2.
  - A CDB wakeup at t gives the earliest issue_valid at t+2.
- free_count = RS_SIZE - popcount(valid), registered; ±1 per cycle, net 0 on simultaneous dispatch and issue.
- Squash:
  - Clears all valid bits and issue_valid at the next edge; free_count = RS_SIZE.
  - Overrides dispatch, wakeup and issue in the same cycle.
- Asynchronous reset mid-operation drops all in-flight entries, including one being handed to the FU.

Decomposition:
- Shared package holds:
  - rs_entry_t struct: valid, pc, op, dest, src1, rdy1, src2, rdy2.
  - issue_pkt_t struct: pc, op, dest, src1, src2.
  - RS_SIZE, TAG_W, OP_W constants.
- One natural sub-module: rs_oldest_sel16. It takes req[15:0], pc[15:0][XLEN-1:0] and en, and gives gnt[15:0] one-hot, req_up and pc_up, with the tie rule above.
- The free-entry finder reuses the existing fixed-priority selector, driven with bit-reversed ~valid so the lowest index wins.

Test Plan:
- Reset, then dispatch pc=0x100 with rdy1=rdy2=1 at cycle 1 -> issue_valid=1 and issue_pc=0x100 at cycle 3; free_count 16->15->16.
- Dispatch pc=0x300, 0x200, 0x100, all ready, on consecutive cycles, with issue_ready=1 -> issue order 0x100, 0x200, 0x300 if all are resident before the first selection; otherwise order among the entries resident at each selection.
- Dispatch pc=0x40 with src1=7 not ready, then cdb_tag=7 two cycles later -> issue_valid exactly 2 cycles after the CDB cycle. Dispatch and cdb_tag=7 in the same cycle -> stored ready (bypass).
- Hold issue_ready=0 with 3 ready entries -> slot contents stable, free_count stays at 13. Raise issue_ready -> one issue per cycle, oldest first.
- Fill 16 entries -> dispatch_ready=0; a 17th dispatch_valid is dropped. After one issue, dispatch_ready=1 in the following cycle.
- Two ready entries both with pc=0x80 in entries 3 and 9 -> entry 3 is granted first. Assert squash mid-stream -> next cycle issue_valid=0 and free_count=16; assert reset=0 asynchronously -> immediate clear.
